// File: rtl/excp_pkg.sv
// Shared exception types and codes: flush FSM states, commit kind, and ECODE values.
// Used by the flush controller as well as decode and CSR logic.
package excp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedir
    } flush_state_t;

    typedef enum logic {
        KindExcp,
        KindErtn
    } excp_kind_t;

    localparam logic [5:0] EcodeInt  = 6'h00;
    localparam logic [5:0] EcodeAdef = 6'h08;
    localparam logic [5:0] EcodeAle  = 6'h09;
    localparam logic [5:0] EcodeSys  = 6'h0B;
    localparam logic [5:0] EcodeBrk  = 6'h0C;
    localparam logic [5:0] EcodeIne  = 6'h0D;

endpackage

// File: rtl/excp_flush_ctrl.sv
// Exception / ertn flush sequencer: flush pulse, CSR strobe, drain window, then a
// handshaked PC redirect to IF.
module excp_flush_ctrl
    import excp_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 1,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_excp,
    input  logic              id_excp,
    input  logic              ex_excp,
    input  logic              me_excp,
    input  logic              wb_excp,
    input  logic              wb_ertn,
    input  logic [5:0]        wb_ecode,
    input  logic [8:0]        wb_esubcode,
    input  logic [ADDR_W-1:0] wb_pc,
    input  logic [ADDR_W-1:0] csr_eentry,
    input  logic [ADDR_W-1:0] csr_era,
    input  logic              redirect_ready,
    output logic              global_flush_flag,
    output logic              flush_req,
    output logic              excp_wr,
    output logic [5:0]        excp_ecode,
    output logic [8:0]        excp_esubcode,
    output logic [ADDR_W-1:0] excp_era,
    output logic              ertn_wr,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
);

    localparam int unsigned CntW = 4;

    flush_state_t      state_q, state_d;
    excp_kind_t        kind_q, kind_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              strobe_q, strobe_d;
    logic [5:0]        ecode_q, ecode_d;
    logic [8:0]        esub_q, esub_d;
    logic [ADDR_W-1:0] era_q, era_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              commit;

    assign commit = (wb_excp | wb_ertn) & (state_q == StIdle);

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        target_d = target_q;
        unique case (state_q)
            StIdle: begin
                if (commit) begin
                    state_d  = StFlush;
                    cnt_d    = CntW'(DRAIN_CYCLES - 1);
                    strobe_d = 1'b1;
                    // wb_excp has priority when both commit together
                    if (wb_excp) begin
                        kind_d   = KindExcp;
                        ecode_d  = wb_ecode;
                        esub_d   = wb_esubcode;
                        era_d    = wb_pc;
                        target_d = csr_eentry;
                    end else begin
                        kind_d   = KindErtn;
                        target_d = csr_era;
                    end
                end
            end
            StFlush: begin
                if (cnt_q == '0) begin
                    state_d = StRedir;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRedir: begin
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            kind_q   <= KindExcp;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            target_q <= target_d;
        end
    end

    assign global_flush_flag = ((if_excp | id_excp | ex_excp | me_excp) & ~commit)
                             | (state_q != StIdle);
    assign flush_req      = (state_q == StFlush);
    assign excp_wr        = strobe_q & (kind_q == KindExcp);
    assign ertn_wr        = strobe_q & (kind_q == KindErtn);
    assign excp_ecode     = ecode_q;
    assign excp_esubcode  = esub_q;
    assign excp_era       = era_q;
    assign redirect_valid = (state_q == StRedir);
    assign redirect_pc    = target_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// Scoreboard bench for excp_flush_ctrl: stimulus queues expected CSR strobes and
// redirects; a monitor pops and compares them as the DUT presents them.
module tb_excp_flush_ctrl;
    import excp_pkg::*;

    localparam int unsigned D  = 2;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_excp = 0, id_excp = 0, ex_excp = 0, me_excp = 0;
    logic          wb_excp = 0, wb_ertn = 0;
    logic [5:0]    wb_ecode = '0;
    logic [8:0]    wb_esubcode = '0;
    logic [AW-1:0] wb_pc = '0, csr_eentry = '0, csr_era = '0;
    logic          redirect_ready = 1'b1;
    logic          global_flush_flag, flush_req, excp_wr, ertn_wr, redirect_valid, busy;
    logic [5:0]    excp_ecode;
    logic [8:0]    excp_esubcode;
    logic [AW-1:0] excp_era, redirect_pc;

    excp_flush_ctrl #(.DRAIN_CYCLES(D), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .if_excp(if_excp), .id_excp(id_excp), .ex_excp(ex_excp), .me_excp(me_excp),
        .wb_excp(wb_excp), .wb_ertn(wb_ertn), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .csr_eentry(csr_eentry),
        .csr_era(csr_era), .redirect_ready(redirect_ready),
        .global_flush_flag(global_flush_flag), .flush_req(flush_req),
        .excp_wr(excp_wr), .excp_ecode(excp_ecode), .excp_esubcode(excp_esubcode),
        .excp_era(excp_era), .ertn_wr(ertn_wr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit            is_excp;
        logic [5:0]    ecode;
        logic [8:0]    esub;
        logic [AW-1:0] era;
        int            cyc;
    } strobe_t;

    typedef struct {
        logic [AW-1:0] pc;
        int            cyc;
    } redir_t;

    strobe_t sq[$];
    redir_t  rq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one commit, queue its expected strobe (and redirect if ready stays high).
    task automatic do_commit(input bit ex, input bit er, input logic [5:0] ecode,
                             input logic [8:0] esub, input logic [AW-1:0] pc,
                             input logic [AW-1:0] eentry, input logic [AW-1:0] era,
                             input bit push_redir);
        strobe_t s;
        redir_t  r;
        wb_excp     = ex;
        wb_ertn     = er;
        wb_ecode    = ecode;
        wb_esubcode = esub;
        wb_pc       = pc;
        csr_eentry  = eentry;
        csr_era     = era;
        s.is_excp = ex;
        s.ecode   = ecode;
        s.esub    = esub;
        s.era     = pc;
        s.cyc     = cyc + 1;
        sq.push_back(s);
        if (push_redir) begin
            r.pc  = ex ? eentry : era;
            r.cyc = cyc + 1 + D;
            rq.push_back(r);
        end
        step();
        wb_excp = 0;
        wb_ertn = 0;
    endtask

    // Monitor
    initial begin
        strobe_t s;
        redir_t  r;
        forever begin
            @(negedge clk);
            if (excp_wr || ertn_wr) begin
                if (sq.size() == 0) begin
                    check("unexpected_strobe", {excp_wr, ertn_wr}, 0);
                end else begin
                    s = sq.pop_front();
                    check("strobe_excp_wr", excp_wr, s.is_excp);
                    check("strobe_ertn_wr", ertn_wr, !s.is_excp);
                    check("strobe_cycle", cyc, s.cyc);
                    if (s.is_excp) begin
                        check("excp_ecode", excp_ecode, s.ecode);
                        check("excp_esubcode", excp_esubcode, s.esub);
                        check("excp_era", excp_era, s.era);
                    end
                end
            end
            if (redirect_valid && redirect_ready) begin
                if (rq.size() == 0) begin
                    check("unexpected_redirect", redirect_pc, 0);
                end else begin
                    r = rq.pop_front();
                    check("redirect_pc", redirect_pc, r.pc);
                    check("redirect_cycle", cyc, r.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] held_pc;
        // Reset state
        step();
        step();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_flush_req", flush_req, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_excp_era", excp_era, 0);
        check("rst_excp_ecode", excp_ecode, 0);
        check("rst_gff", global_flush_flag, 0);
        reset = 1'b1;
        step();

        // Uncommitted exception in EX: combinational flag only
        ex_excp = 1;
        #1;
        check("gff_ex_excp", global_flush_flag, 1);
        check("gff_flush_req", flush_req, 0);
        check("gff_busy", busy, 0);
        ex_excp = 0;
        #1;
        check("gff_clear", global_flush_flag, 0);
        step();

        // Exception commit, SYS at 0x1C000100
        do_commit(1, 0, EcodeSys, 9'h0, 32'h1C00_0100, 32'h1C00_8000, 32'h0, 1);
        @(negedge clk);
        check("excp_t1_flush", flush_req, 1);
        check("excp_t1_busy", busy, 1);
        check("excp_t1_gff", global_flush_flag, 1);
        step();
        @(negedge clk);
        check("excp_t2_flush", flush_req, 1);
        check("excp_t2_excp_wr", excp_wr, 0);
        step();
        @(negedge clk);
        check("excp_t3_flush", flush_req, 0);
        check("excp_t3_rv", redirect_valid, 1);
        step();
        @(negedge clk);
        check("excp_t4_busy", busy, 0);
        check("excp_t4_rv", redirect_valid, 0);
        step();

        // ertn commit
        do_commit(0, 1, 6'h0, 9'h0, 32'h0, 32'h0, 32'h1C00_0204, 1);
        @(negedge clk);
        check("ertn_flush", flush_req, 1);
        repeat (D + 1) step();
        @(negedge clk);
        check("ertn_done_busy", busy, 0);
        check("ertn_keeps_era", excp_era, 32'h1C00_0100);
        check("ertn_keeps_ecode", excp_ecode, EcodeSys);
        step();

        // Stalled redirect with wb_excp toggling
        redirect_ready = 0;
        do_commit(1, 0, EcodeIne, 9'h1A5, 32'h1C00_0300, 32'h1C00_8040, 32'h0, 0);
        repeat (D) step();
        for (int i = 0; i < 3; i++) begin
            wb_excp  = (i % 2 == 0);
            wb_ecode = EcodeBrk;
            @(negedge clk);
            check("stall_rv", redirect_valid, 1);
            check("stall_pc", redirect_pc, 32'h1C00_8040);
            check("stall_flush", flush_req, 0);
            step();
        end
        wb_excp = 0;
        begin
            redir_t r;
            r.pc  = 32'h1C00_8040;
            r.cyc = cyc;
            rq.push_back(r);
        end
        redirect_ready = 1;
        step();
        @(negedge clk);
        check("stall_done_busy", busy, 0);
        step();

        // Simultaneous excp and ertn: excp wins
        do_commit(1, 1, EcodeBrk, 9'h003, 32'h1C00_0500, 32'h1C00_8080, 32'h1C00_0600, 1);
        @(negedge clk);
        check("both_ertn_wr", ertn_wr, 0);
        repeat (D + 1) step();
        @(negedge clk);
        check("both_done_busy", busy, 0);
        step();

        // Reset in FLUSH abandons the sequence
        do_commit(1, 0, EcodeAle, 9'h0, 32'h1C00_0700, 32'h1C00_80C0, 32'h0, 0);
        @(negedge clk);
        check("rstmid_flush", flush_req, 1);
        reset = 0;
        step();
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_flush_req", flush_req, 0);
        check("rstmid_excp_wr", excp_wr, 0);
        check("rstmid_ertn_wr", ertn_wr, 0);
        check("rstmid_rv", redirect_valid, 0);
        check("rstmid_pc", redirect_pc, 0);
        check("rstmid_era", excp_era, 0);
        reset = 1;
        step();
        held_pc = redirect_pc;
        repeat (D + 2) step();
        @(negedge clk);
        check("rstmid_no_restart", busy, 0);
        check("rstmid_pc_hold", redirect_pc, held_pc);

        check("strobe_queue_empty", sq.size(), 0);
        check("redir_queue_empty", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/excp_flush_ctrl.md
# excp_flush_ctrl

Sequences the pipeline-wide flush and PC redirect for exceptions and `ertn` in the LoongArch core. It raises a combinational flush-pending flag whenever any stage holds an uncommitted exception. On a WB-stage exception or `ertn` commit it runs a fixed sequence: flush pulse, CSR update strobes, a drain window, then a handshaked redirect to the IF PC unit. It sits between the stage exception signals, the CSR file and the IF PC-select logic.

## Interface
Parameters:
- `DRAIN_CYCLES`, 1: number of cycles `flush_req` is held. Legal range is 1 to 15.
- `ADDR_W`, 32: PC/address width.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `if_excp`, `id_excp`, `ex_excp`, `me_excp`  in  1 each  exception tagged in that stage.
- `wb_excp`  in  1  exception instruction commits at WB this cycle.
- `wb_ertn`  in  1  `ertn` commits at WB this cycle.
- `wb_ecode`  in  6  exception code.
- `wb_esubcode`  in  9  exception subcode.
- `wb_pc`  in  ADDR_W  PC of the committing instruction.
- `csr_eentry`, `csr_era`  in  ADDR_W  current CSR values.
- `redirect_ready`  in  1  IF accepts the redirect.
- `global_flush_flag`  out  1  suppresses store and CSR side effects of younger instructions.
- `flush_req`  out  1  clears every stage's valid bit.
- `excp_wr`  out  1  one-cycle strobe; CSR file saves ESTAT/ERA/PRMD.
- `excp_ecode`  out  6  latched exception code.
- `excp_esubcode`  out  9  latched exception subcode.
- `excp_era`  out  ADDR_W  latched PC to be written to ERA.
- `ertn_wr`  out  1  one-cycle strobe; CSR file restores CRMD from PRMD.
- `redirect_valid`  out  1  redirect request to IF.
- `redirect_pc`  out  ADDR_W  redirect target.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `commit` = (`wb_excp` | `wb_ertn`) & state==IDLE.
- `global_flush_flag` = ((`if_excp`|`id_excp`|`ex_excp`|`me_excp`) & ~`commit`) | state!=IDLE. This output is combinational.

FSM states: IDLE, FLUSH, REDIR.
- **IDLE → FLUSH on `commit`.**
  - Latch `kind`: excp if `wb_excp`, else ertn. `wb_excp` wins if both are asserted in the same cycle.
  - For excp: latch `wb_ecode`, `wb_esubcode`, `wb_pc`, and take the target from `csr_eentry`.
  - For ertn: take the target from `csr_era`.
  - Load `drain_cnt` with DRAIN_CYCLES-1.
- **FLUSH:**
  - `flush_req`=1.
  - `excp_wr` (excp) or `ertn_wr` (ertn) is high only in the first FLUSH cycle.
  - `drain_cnt` decrements each cycle. When it reaches 0, go to REDIR.
- **REDIR:**
  - `redirect_valid`=1 with a stable `redirect_pc`.
  - When `redirect_valid` & `redirect_ready`, go to IDLE. The redirect is not retracted.
- `wb_excp` and `wb_ertn` are ignored outside IDLE; the flush guarantees no legal commit arrives there.
- `excp_ecode`, `excp_esubcode` and `excp_era` hold their last latched values until the next excp commit.
- `ertn` does not modify them.

## Timing
- Commit is sampled at cycle T. Then:
  - `flush_req` is high from T+1 to T+DRAIN_CYCLES.
  - `excp_wr`/`ertn_wr` pulses at T+1.
  - `redirect_valid` rises at T+DRAIN_CYCLES+1.
- Minimum turnaround, with `redirect_ready` already high: IDLE is re-entered at T+DRAIN_CYCLES+2.
- Reset values (`reset`=0 at any edge, including mid-sequence):
  - state IDLE, `drain_cnt` 0.
  - All strobes 0.
  - `redirect_pc`, `excp_era`, `excp_ecode`, `excp_esubcode` all 0.
- A reset during FLUSH or REDIR abandons the sequence. No partial `excp_wr` is re-issued.
- All outputs except `global_flush_flag` are registered.

## Structure
- A shared package `excp_pkg` holds:
  - The state enum `flush_state_t` (IDLE/FLUSH/REDIR).
  - The `kind` enum.
  - ECODE constants, also used by the decode and CSR logic: INT 0x00, ADEF 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D.
- No sub-module. The counter and FSM are kept inline.

## Test plan
- `ex_excp`=1, no commit → `global_flush_flag`=1 in the same cycle; `flush_req`=0; `busy`=0.
- DRAIN_CYCLES=2; `wb_excp` at T with `wb_ecode`=0x0B, `wb_pc`=0x1C000100, `csr_eentry`=0x1C008000; `redirect_ready`=1 → expected response:
  - `flush_req`=1 at T+1 and T+2.
  - `excp_wr` at T+1 only, with `excp_era`=0x1C000100 and `excp_ecode`=0x0B.
  - `redirect_valid` at T+3 with `redirect_pc`=0x1C008000.
  - IDLE at T+4.
- `wb_ertn` with `csr_era`=0x1C000204 → `ertn_wr` pulse; `excp_wr`=0; `redirect_pc`=0x1C000204.
- `redirect_ready`=0 for 3 cycles in REDIR while `wb_excp` toggles → `redirect_valid`/`redirect_pc` stay stable and no new sequence starts.
- `wb_excp` and `wb_ertn` both asserted → excp path is taken (`excp_wr`=1, target is `csr_eentry`).
- `reset`=0 during FLUSH → next cycle `busy`=0, all strobes 0, `redirect_pc`=0.
